traffic_lights_cfg_seq: RTL and testbench
=========================================

TRAFFIC_LIGHTS_CFG_SEQ -- requirements
Module: traffic_lights_cfg_seq

Upstream command sequencer for traffic_lights. It accepts one timing set (red/yellow/green) per handshake and drives traffic_lights' cmd_type/cmd_valid/cmd_data port with the fixed programming sequence.

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: idle cycles between the OFF command and the first SET command (0 allowed).
REQ-002 SHALL have parameter MAX_TIME, default 16'd1000: largest legal duration value.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port srst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid_i  input  1  a timing set is offered.
REQ-006 SHALL have port cfg_ready_o  output  1  the block accepts a timing set.
REQ-007 SHALL have ports cfg_red_i, cfg_yellow_i, cfg_green_i  input  16 each  durations, sampled at handshake.
REQ-008 SHALL have port cmd_type_o  output  3  command code to traffic_lights.
REQ-009 SHALL have port cmd_valid_o  output  1  command strobe.
REQ-010 SHALL have port cmd_data_o  output  16  command payload.
REQ-011 SHALL have port busy_o  output  1  a sequence is in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse: sequence completed.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse: timing set rejected.

Function
REQ-014 SHALL use command codes 0=ON, 1=OFF, 3=SET_GREEN, 4=SET_RED, 5=SET_YELLOW; no other code is ever driven.
REQ-015 SHALL complete a handshake on a rising edge where cfg_valid_i=1 and cfg_ready_o=1, and SHALL capture all three durations at that edge.
REQ-016 SHALL drive cfg_ready_o=1 only in state IDLE; cfg_ready_o SHALL NOT depend combinationally on cfg_valid_i.
REQ-017 SHALL implement the states IDLE, OFF, HOLD, SET_G, SET_R, SET_Y, ON, DONE.
REQ-018 SHALL treat a timing set as valid only if every duration is in the range 1..MAX_TIME.
REQ-019 SHALL, on a handshake of a valid set, go IDLE->OFF; each of OFF, SET_G, SET_R, SET_Y and ON SHALL last exactly one cycle.
REQ-020 SHALL, in HOLD, count HOLD_CYCLES cycles and then go to SET_G; with HOLD_CYCLES=0, OFF SHALL go directly to SET_G.
REQ-021 SHALL step SET_G->SET_R->SET_Y->ON->DONE->IDLE; DONE SHALL last one cycle.
REQ-022 SHALL drive cmd_valid_o=1 only in OFF, SET_G, SET_R, SET_Y and ON.
REQ-023 SHALL drive cmd_type_o = 1, 3, 4, 5, 0 in OFF, SET_G, SET_R, SET_Y, ON respectively; cmd_type_o SHALL be 0 in all other states.
REQ-024 SHALL drive cmd_data_o = captured green, red, yellow in SET_G, SET_R, SET_Y respectively; cmd_data_o SHALL be 0 in all other states.
REQ-025 SHALL register all outputs; the OFF command SHALL appear in the cycle after the handshake edge.
REQ-026 SHALL assert busy_o in every state except IDLE.
REQ-027 SHALL assert done_o only in DONE, which is the cycle after ON; cfg_ready_o SHALL return to 1 in the following cycle.
REQ-028 SHALL, on a handshake of an invalid set, issue no command, stay in IDLE, and pulse err_o for exactly one cycle in the cycle after the handshake.
REQ-029 SHALL accept a new handshake in the same cycle as an err_o pulse (back-to-back offers are allowed).
REQ-030 SHALL ignore cfg_valid_i and the cfg_*_i inputs while busy_o=1; captured values SHALL NOT change mid-sequence.
REQ-031 SHALL give a valid-set sequence a total length of 5+HOLD_CYCLES cycles from the OFF cycle through the ON cycle inclusive.

Reset
REQ-032 SHALL, when srst_i=1 at a rising edge, enter IDLE and set cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, busy_o=0, done_o=0, err_o=0, cfg_ready_o=1 and captured durations=0 after that edge.
REQ-033 SHALL let srst_i override any handshake in the same cycle; a reset mid-sequence SHALL abort the sequence without issuing ON or done_o.
REQ-034 SHALL need no reset-release cycles: a handshake SHALL be accepted in the first cycle with srst_i=0.

Verification
REQ-035 SHALL cover: reset, then offer red=50, yellow=30, green=70 -> OFF one cycle after the handshake, 10 idle cycles, then (3,70),(4,50),(5,30),(0,0) on consecutive cycles, done_o in the next cycle.
REQ-036 SHALL cover: HOLD_CYCLES=0 with red=1, yellow=1000, green=2 -> OFF immediately followed by SET_G(2), SET_R(1), SET_Y(1000), ON; busy_o high for exactly 6 cycles.
REQ-037 SHALL cover: offer yellow=0, then separately red=1001 -> no cmd_valid_o, err_o one-cycle pulse each time, cfg_ready_o stays 1.
REQ-038 SHALL cover: cfg_valid_i held high with changing data during a sequence -> no second capture; SET payloads match the first set.
REQ-039 SHALL cover: srst_i asserted during HOLD -> all outputs 0 after the reset edge, no ON or done_o; a new set accepted in the first cycle after reset runs correctly.
REQ-040 SHALL cover: this block driving a traffic_lights instance with red=20, green=40, yellow=60 -> red, green and yellow phases match the programmed durations.

Source files
------------

// File: rtl/traffic_lights_cfg_seq.sv
// Command sequencer that programs a traffic_lights block: on each accepted timing
// set it issues OFF, waits HOLD_CYCLES, then SET_G/SET_R/SET_Y and ON, one per cycle.
module traffic_lights_cfg_seq #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [15:0] MAX_TIME    = 16'd1000
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [15:0] cfg_red_i,
    input  logic [15:0] cfg_yellow_i,
    input  logic [15:0] cfg_green_i,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OFF   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_SET_G = 3'd3;
    localparam logic [2:0] S_SET_R = 3'd4;
    localparam logic [2:0] S_SET_Y = 3'd5;
    localparam logic [2:0] S_ON    = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [2:0] CMD_ON    = 3'd0;
    localparam logic [2:0] CMD_OFF   = 3'd1;
    localparam logic [2:0] CMD_SET_G = 3'd3;
    localparam logic [2:0] CMD_SET_R = 3'd4;
    localparam logic [2:0] CMD_SET_Y = 3'd5;

    // Counter is at least one bit wide even when HOLD_CYCLES is 0 (HOLD is then unreachable).
    localparam int unsigned     CW        = $clog2(HOLD_CYCLES + 2);
    localparam logic [CW-1:0]   HOLD_LAST = CW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]   red_q, yellow_q, green_q;
    logic          cfg_ready_q, cmd_valid_q, busy_q, done_q, err_q;
    logic [2:0]    cmd_type_q;
    logic [15:0]   cmd_data_q;
    logic          cmd_valid_d;
    logic [2:0]    cmd_type_d;
    logic [15:0]   cmd_data_d;
    logic          handshake, set_ok;

    function automatic logic in_range(input logic [15:0] v);
        return (v != 16'd0) && (v <= MAX_TIME);
    endfunction

    assign handshake = cfg_valid_i & cfg_ready_q;
    assign set_ok    = in_range(cfg_red_i) & in_range(cfg_yellow_i) & in_range(cfg_green_i);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE:  if (handshake && set_ok) state_d = S_OFF;
            S_OFF: begin
                hold_cnt_d = '0;
                state_d    = (HOLD_CYCLES == 0) ? S_SET_G : S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_SET_G;
                else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            S_SET_G: state_d = S_SET_R;
            S_SET_R: state_d = S_SET_Y;
            S_SET_Y: state_d = S_ON;
            S_ON:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops aligned with the state.
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_type_d  = CMD_ON;
        cmd_data_d  = 16'd0;
        case (state_d)
            S_OFF:   begin cmd_valid_d = 1'b1; cmd_type_d = CMD_OFF; end
            S_SET_G: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_SET_G; cmd_data_d = green_q; end
            S_SET_R: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_SET_R; cmd_data_d = red_q; end
            S_SET_Y: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_SET_Y; cmd_data_d = yellow_q; end
            S_ON:    begin cmd_valid_d = 1'b1; cmd_type_d = CMD_ON; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            red_q       <= 16'd0;
            yellow_q    <= 16'd0;
            green_q     <= 16'd0;
            cfg_ready_q <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (handshake) begin
                red_q    <= cfg_red_i;
                yellow_q <= cfg_yellow_i;
                green_q  <= cfg_green_i;
            end
            cfg_ready_q <= (state_d == S_IDLE);
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            err_q       <= handshake & ~set_ok;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_traffic_lights_cfg_seq.sv
// Randomized scoreboard bench: two sequencers (HOLD_CYCLES 10 and 0) share stimulus;
// a timeline model predicts every command/done/err pulse by cycle number.
module tb_traffic_lights_cfg_seq;
    localparam int          H0   = 10;
    localparam int          H1   = 0;
    localparam logic [15:0] MAXT = 16'd1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst, cfg_valid;
    logic [15:0] red, yel, grn;
    logic        rdy [2];
    logic        cv  [2];
    logic        busy[2];
    logic        done[2];
    logic        err [2];
    logic [2:0]  ct  [2];
    logic [15:0] cd  [2];

    traffic_lights_cfg_seq #(.HOLD_CYCLES(H0), .MAX_TIME(MAXT)) u0 (
        .clk_i(clk), .srst_i(srst), .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy[0]),
        .cfg_red_i(red), .cfg_yellow_i(yel), .cfg_green_i(grn),
        .cmd_type_o(ct[0]), .cmd_valid_o(cv[0]), .cmd_data_o(cd[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]));

    traffic_lights_cfg_seq #(.HOLD_CYCLES(H1), .MAX_TIME(MAXT)) u1 (
        .clk_i(clk), .srst_i(srst), .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy[1]),
        .cfg_red_i(red), .cfg_yellow_i(yel), .cfg_green_i(grn),
        .cmd_type_o(ct[1]), .cmd_valid_o(cv[1]), .cmd_data_o(cd[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]));

    typedef struct {
        int          cyc;
        logic        v;
        logic [2:0]  t;
        logic [15:0] d;
        logic        dn;
        logic        er;
    } exp_t;

    exp_t q[2][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_ok[2] = '{2, 2};
    int   busy_lo[2] = '{0, 0};
    int   busy_hi[2] = '{-1, -1};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void push(int d, int c, logic v, logic [2:0] t, logic [15:0] dd,
                                 logic dn, logic er);
        exp_t e;
        e.cyc = c; e.v = v; e.t = t; e.d = dd; e.dn = dn; e.er = er;
        q[d].push_back(e);
    endfunction

    function automatic bit legal(logic [15:0] v);
        return v >= 16'd1 && v <= MAXT;
    endfunction

    // Predict what each DUT does at the coming edge, given the inputs now applied.
    task automatic model_edge();
        int e = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            int h = (d == 0) ? H0 : H1;
            if (srst) begin
                while (q[d].size() > 0 && q[d][$].cyc >= e) void'(q[d].pop_back());
                next_ok[d] = e + 1;
                if (busy_hi[d] >= e) busy_hi[d] = e - 1;
            end else if (cfg_valid && e >= next_ok[d]) begin
                if (legal(red) && legal(yel) && legal(grn)) begin
                    push(d, e,         1'b1, 3'd1, 16'd0, 1'b0, 1'b0);
                    push(d, e + 1 + h, 1'b1, 3'd3, grn,   1'b0, 1'b0);
                    push(d, e + 2 + h, 1'b1, 3'd4, red,   1'b0, 1'b0);
                    push(d, e + 3 + h, 1'b1, 3'd5, yel,   1'b0, 1'b0);
                    push(d, e + 4 + h, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0);
                    push(d, e + 5 + h, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
                    busy_lo[d] = e;
                    busy_hi[d] = e + 5 + h;
                    next_ok[d] = e + 7 + h;
                end else begin
                    push(d, e, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
                    next_ok[d] = e + 1;
                end
            end
        end
    endtask

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(int d, string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s cycle %0d: got %0d expected %0d", d, nm, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, compare all outputs against the predicted timeline.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_t x;
            logic eb;
            x.cyc = cyc; x.v = 1'b0; x.t = 3'd0; x.d = 16'd0; x.dn = 1'b0; x.er = 1'b0;
            if (q[d].size() > 0 && q[d][0].cyc == cyc) x = q[d].pop_front();
            eb = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
            chk(d, "cmd_valid", 16'(cv[d]),   16'(x.v));
            chk(d, "cmd_type",  16'(ct[d]),   16'(x.t));
            chk(d, "cmd_data",  cd[d],        x.d);
            chk(d, "done",      16'(done[d]), 16'(x.dn));
            chk(d, "err",       16'(err[d]),  16'(x.er));
            chk(d, "busy",      16'(busy[d]), 16'(eb));
            chk(d, "cfg_ready", 16'(rdy[d]),  16'(!eb));
        end
    end

    task automatic offer(logic [15:0] r, logic [15:0] y, logic [15:0] g);
        cfg_valid = 1'b1; red = r; yel = y; grn = g;
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [15:0] rnd_dur();
        case ($urandom % 10)
            0:       return 16'd0;
            1:       return 16'(1001 + $urandom % 200);
            2:       return 16'd1000;
            3:       return 16'd1;
            default: return 16'($urandom_range(1, 1000));
        endcase
    endfunction

    initial begin
        srst = 1'b1; cfg_valid = 1'b0; red = 16'd0; yel = 16'd0; grn = 16'd0;
        @(posedge clk);
        #1;
        step(2);
        srst = 1'b0;
        // Nominal set, then the boundary set (1, 1000, 2).
        offer(16'd50, 16'd30, 16'd70);
        step(20);
        offer(16'd1, 16'd1000, 16'd2);
        step(20);
        // Rejected sets, then back-to-back invalid then valid offers.
        offer(16'd10, 16'd0, 16'd10);
        step(2);
        offer(16'd1001, 16'd10, 16'd10);
        step(2);
        offer(16'd0, 16'd5, 16'd5);
        offer(16'd7, 16'd8, 16'd9);
        step(20);
        // Valid held high with changing data across a whole sequence.
        for (int i = 0; i < 25; i++) begin
            cfg_valid = 1'b1;
            red = 16'($urandom_range(1, 1000));
            yel = 16'($urandom_range(1, 1000));
            grn = 16'($urandom_range(1, 1000));
            step();
        end
        cfg_valid = 1'b0;
        step(20);
        // Reset mid-sequence, then a set offered in the first cycle after reset.
        offer(16'd11, 16'd22, 16'd33);
        step(3);
        srst = 1'b1;
        step();
        srst = 1'b0;
        offer(16'd44, 16'd55, 16'd66);
        step(20);
        offer(16'd20, 16'd60, 16'd40);
        step(20);
        // Random traffic including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            srst      = ($urandom % 100) == 0;
            cfg_valid = ($urandom % 3) == 0;
            red = rnd_dur(); yel = rnd_dur(); grn = rnd_dur();
            step();
        end
        srst = 1'b0; cfg_valid = 1'b0;
        step(25);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk(d, "pending_events", 16'(q[d].size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
